// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/sub cells: FSM state encoding
// and the helper that sizes the bit counter.
package addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Counter must be able to represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_add.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial
// add/sub datapaths.
module full_add (
  input  logic A,
  input  logic B,
  input  logic C_I,
  output logic S,
  output logic C_O
);

  assign S   = A ^ B ^ C_I;
  assign C_O = (A & B) | (C_I & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop process the
// operands LSB-first, giving {C_O,S} = A + B + C_I after WIDTH RUN cycles.
module serial_adder
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_I,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             C_O
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic             c_o_reg;
  logic [CW-1:0]    cnt_reg;

  logic             cell_s;
  logic             cell_c;
  logic             accept;
  logic             last_edge;

  full_add u_cell (
    .A   (a_reg[0]),
    .B   (b_reg[0]),
    .C_I (carry_reg),
    .S   (cell_s),
    .C_O (cell_c)
  );

  assign accept    = (state_reg == ST_IDLE) && START;
  assign last_edge = (state_reg == ST_RUN) && (cnt_reg == LAST_BIT);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (START)     state_next = ST_RUN;
      ST_RUN:  if (last_edge) state_next = ST_FIN;
      ST_FIN:                 state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_reg)
      ST_RUN:  BUSY = 1'b1;
      ST_FIN:  DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      c_o_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      carry_reg <= C_I;
      cnt_reg   <= '0;
    end else if (state_reg == ST_RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      s_reg     <= {cell_s, s_reg[WIDTH-1:1]};
      carry_reg <= cell_c;
      cnt_reg   <= cnt_reg + CW'(1);
      // Latch carry-out as FIN is entered so it is valid alongside DONE.
      if (last_edge) begin
        c_o_reg <= cell_c;
      end
    end
  end

  assign S   = s_reg;
  assign C_O = c_o_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vector table,
// multi-cycle corner sequences, and random operations against a + b + ci.
module tb_serial_adder;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_I;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] S;
  logic         C_O;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .C_I   (C_I),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .C_O   (C_O)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and watch it to completion (bounded).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output logic [W-1:0] s_o, output logic co_o,
                        output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = -1;
    s_o     = 'x;
    co_o    = 1'bx;
    @(negedge CLK);
    A = a; B = b; C_I = ci; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); C_I = 1'($urandom);
    for (int k = 1; k <= W + 6 && done_at < 0; k++) begin
      if (k > 1) @(negedge CLK);
      if (BUSY) busy_n++;
      if (DONE) begin
        done_at = k;
        s_o     = S;
        co_o    = C_O;
      end
    end
  endtask

  vec_t         vecs[6];
  logic [W-1:0] s_got;
  logic         co_got;
  int           busy_n;
  int           done_at;
  int           n_done;
  int           prev_done;
  logic [W:0]   ref_sum;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rci;

  initial begin
    vecs[0] = '{"5a+3c",      8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{"ff+01",      8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{"ff+ff+1",    8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{"00+00+1",    8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{"80+80",      8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{"7f+00+1",    8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; C_I = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_s",    32'(S),    32'd0);
    check("reset_co",   32'(C_O),  32'd0);
    RST_N = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, s_got, co_got, busy_n, done_at);
      $display("op %s: S=0x%0h C_O=%0d busy=%0d done_at=%0d", vecs[i].name, s_got, co_got, busy_n, done_at);
      check({vecs[i].name, "_s"},       32'(s_got),  32'(vecs[i].s));
      check({vecs[i].name, "_co"},      32'(co_got), 32'(vecs[i].co));
      check({vecs[i].name, "_busy"},    32'(busy_n), 32'(W));
      check({vecs[i].name, "_done_at"}, 32'(done_at), 32'(W + 1));
      @(negedge CLK);
      check({vecs[i].name, "_s_hold"},  32'(S),    32'(vecs[i].s));
      check({vecs[i].name, "_co_hold"}, 32'(C_O),  32'(vecs[i].co));
      check({vecs[i].name, "_done_1cy"}, 32'(DONE), 32'd0);
    end

    // START during RUN is ignored
    @(negedge CLK);
    A = 8'h5A; B = 8'h3C; C_I = 1'b0; START = 1'b1;
    n_done = 0; s_got = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (k == 4) begin A = 8'h01; B = 8'h01; START = 1'b1; end
      if (DONE) begin n_done++; s_got = S; end
    end
    START = 1'b0;
    $display("op ignore_start: S=0x%0h dones=%0d", s_got, n_done);
    check("ignore_dones", 32'(n_done), 32'd1);
    check("ignore_s",     32'(s_got),  32'h96);
    run_op(8'h01, 8'h01, 1'b0, s_got, co_got, busy_n, done_at);
    $display("op fresh_01+01: S=0x%0h C_O=%0d", s_got, co_got);
    check("fresh_s", 32'(s_got), 32'h02);

    // START held high: one result every W+2 cycles
    @(negedge CLK);
    A = 8'h12; B = 8'h34; C_I = 1'b1; START = 1'b1;
    n_done = 0; prev_done = -1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge CLK);
      if (DONE) begin
        n_done++;
        check("cont_s",  32'(S),   32'h47);
        check("cont_co", 32'(C_O), 32'd0);
        if (prev_done < 0) check("cont_first", 32'(k), 32'(W + 1));
        else               check("cont_period", 32'(k - prev_done), 32'(W + 2));
        prev_done = k;
      end
    end
    START = 1'b0;
    $display("op continuous: dones=%0d", n_done);
    check("cont_count", 32'(n_done), 32'd4);
    repeat (15) @(negedge CLK);

    // Reset in the middle of RUN abandons the operation
    @(negedge CLK);
    A = 8'hFF; B = 8'hFF; C_I = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    $display("op mid_reset: BUSY=%0d DONE=%0d S=0x%0h C_O=%0d", BUSY, DONE, S, C_O);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_s",    32'(S),    32'd0);
    check("rst_co",   32'(C_O),  32'd0);
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (DONE) n_done++;
    end
    check("rst_no_done", 32'(n_done), 32'd0);

    // Random operations against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
      ref_sum = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rci);
      run_op(ra, rb, rci, s_got, co_got, busy_n, done_at);
      $display("op rand%0d: %0h+%0h+%0d -> C_O=%0d S=0x%0h", i, ra, rb, rci, co_got, s_got);
      check("rand_sum",     32'({co_got, s_got}), 32'(ref_sum));
      check("rand_done_at", 32'(done_at),         32'(W + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit 2000000 ns");
    $fatal(1, "timeout");
  end

endmodule
